// File: rtl/microseq_engine.sv
// microseq_engine: programmable microprogram sequencer.
// Microcode RAM is loaded through the program port while the engine is not
// running. In RUN one microinstruction is executed per clock; each word
// carries its own control-word field, an opcode, a condition select and
// polarity, and a branch/call target. Calls use a small hardware stack.
module microseq_engine #(
  parameter int AW         = 4,
  parameter int OW         = 1,
  parameter int CW         = 2,
  parameter int SD         = 2,
  parameter int START_ADDR = 0,
  localparam int CSW       = (CW > 1) ? $clog2(CW) : 1,
  localparam int IW        = OW + 3 + CSW + 1 + AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] cond,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  output logic [OW-1:0] out,
  output logic [AW-1:0] upc,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int DEPTH = 2 ** AW;
  localparam int SPW   = $clog2(SD + 1);
  localparam int SDEP  = 2 ** SPW;

  localparam logic [AW-1:0]  ADDR_ONE = AW'(1'b1);
  localparam logic [AW-1:0]  START_V  = AW'(START_ADDR);
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1'b1);
  localparam logic [SPW-1:0] SP_ZERO  = {SPW{1'b0}};
  localparam logic [SPW-1:0] SD_V     = SPW'(SD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Opcode 7 is reserved and is caught by the default branch of the decoder.
  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRC  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_HALT = 3'd5,
    OP_WAIT = 3'd6
  } op_t;

  logic [IW-1:0]  mem_r   [0:DEPTH-1];
  logic [AW-1:0]  stack_r [0:SDEP-1];

  state_t         state_r, state_s;
  logic [AW-1:0]  upc_r, upc_s;
  logic [SPW-1:0] sp_r, sp_s;
  logic           push_s;

  logic [IW-1:0]  instr_s;
  logic [AW-1:0]  tgt_s;
  logic           cpol_s;
  logic [CSW-1:0] csel_s;
  op_t            op_s;
  logic [OW-1:0]  ofield_s;
  logic           cond_hit_s;
  logic [AW-1:0]  upc_inc_s;

  // Field split of the microinstruction currently addressed by the uPC.
  assign instr_s   = mem_r[upc_r];
  assign tgt_s     = instr_s[AW-1:0];
  assign cpol_s    = instr_s[AW];
  assign csel_s    = instr_s[AW+CSW:AW+1];
  assign op_s      = op_t'(instr_s[AW+CSW+3:AW+CSW+1]);
  assign ofield_s  = instr_s[IW-1:IW-OW];
  assign upc_inc_s = upc_r + ADDR_ONE;

  // Condition evaluation; selects beyond the implemented inputs read as zero.
  always_comb begin
    cond_hit_s = cpol_s;
    if (int'(csel_s) < CW) begin
      cond_hit_s = cond[csel_s] ^ cpol_s;
    end else begin
      cond_hit_s = cpol_s;
    end
  end

  // Microcode RAM write port; locked out while a program is executing.
  always_ff @(posedge clk) begin
    if (prog_we && (state_r != ST_RUN)) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

  // Return-address stack storage; pushed on a successful CALL.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[sp_r] <= upc_inc_s;
    end
  end

  // State, uPC and stack-pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      upc_r   <= START_V;
      sp_r    <= SP_ZERO;
    end else begin
      state_r <= state_s;
      upc_r   <= upc_s;
      sp_r    <= sp_s;
    end
  end

  // Next-state decode: launch from any non-running state, execute in RUN.
  always_comb begin
    state_s = state_r;
    upc_s   = upc_r;
    sp_s    = sp_r;
    push_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_s = ST_RUN;
          upc_s   = START_V;
          sp_s    = SP_ZERO;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        case (op_s)
          OP_NEXT: upc_s = upc_inc_s;
          OP_JMP:  upc_s = tgt_s;
          OP_BRC: begin
            if (cond_hit_s) begin
              upc_s = tgt_s;
            end else begin
              upc_s = upc_inc_s;
            end
          end
          OP_CALL: begin
            if (sp_r == SD_V) begin
              state_s = ST_ERROR;
            end else begin
              push_s = 1'b1;
              sp_s   = sp_r + SP_ONE;
              upc_s  = tgt_s;
            end
          end
          OP_RET: begin
            if (sp_r == SP_ZERO) begin
              state_s = ST_ERROR;
            end else begin
              sp_s  = sp_r - SP_ONE;
              upc_s = stack_r[sp_r - SP_ONE];
            end
          end
          OP_HALT: state_s = ST_DONE;
          OP_WAIT: begin
            if (cond_hit_s) begin
              upc_s = upc_inc_s;
            end else begin
              upc_s = upc_r;
            end
          end
          default: state_s = ST_ERROR;
        endcase
      end
      default: begin
        state_s = ST_IDLE;
        upc_s   = START_V;
        sp_s    = SP_ZERO;
      end
    endcase
  end

  // Control word is only driven while executing; status flags follow the state.
  assign out  = (state_r == ST_RUN) ? ofield_s : {OW{1'b0}};
  assign upc  = upc_r;
  assign busy = (state_r == ST_RUN);
  assign done = (state_r == ST_DONE);
  assign err  = (state_r == ST_ERROR);

endmodule

// File: tb/tb_microseq_engine.sv
// Self-checking bench for microseq_engine (default parameters):
// directed vector table, hand-written corner sequences, and a randomized
// phase compared against a behavioural reference model.
module tb_microseq_engine;

  localparam int AW = 4;
  localparam int OW = 1;
  localparam int CW = 2;
  localparam int SD = 2;
  localparam int IW = 10;

  localparam logic [2:0] NX = 3'd0;
  localparam logic [2:0] JP = 3'd1;
  localparam logic [2:0] BR = 3'd2;
  localparam logic [2:0] CL = 3'd3;
  localparam logic [2:0] RT = 3'd4;
  localparam logic [2:0] HL = 3'd5;
  localparam logic [2:0] WT = 3'd6;
  localparam logic [2:0] RS = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] cond;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [OW-1:0] out;
  logic [AW-1:0] upc;
  logic          busy;
  logic          done;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       s;
    logic [1:0] c;
    logic [3:0] upc;
    logic       o;
    logic       b;
    logic       d;
    logic       e;
  } vec_t;

  vec_t tbl[$];

  // Reference model state.
  logic [IW-1:0] m_mem [16];
  bit            m_run;
  bit            m_done;
  bit            m_err;
  int            m_pc;
  int            m_stk[$];

  microseq_engine #(.AW(AW), .OW(OW), .CW(CW), .SD(SD), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .cond(cond),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .out(out), .upc(upc), .busy(busy), .done(done), .err(err)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] enc(input logic o, input logic [2:0] op,
                                         input logic cs, input logic cp,
                                         input logic [3:0] t);
    return {o, op, cs, cp, t};
  endfunction

  task automatic m_reset();
    m_run = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pc = 0;
    m_stk.delete();
  endtask

  // Model of one clock edge, written directly from the instruction rules.
  task automatic m_edge(input logic s, input logic [1:0] c, input logic we,
                        input logic [3:0] a, input logic [IW-1:0] d);
    logic [IW-1:0] w;
    int op;
    bit hit;
    if (!m_run) begin
      if (we) m_mem[a] = d;
      if (s) begin
        m_run = 1'b1; m_done = 1'b0; m_err = 1'b0; m_pc = 0;
        m_stk.delete();
      end
    end else begin
      w   = m_mem[m_pc];
      op  = int'(w[8:6]);
      hit = (int'(w[5]) < CW) ? (c[w[5]] ^ w[4]) : w[4];
      case (op)
        0: m_pc = (m_pc + 1) % 16;
        1: m_pc = int'(w[3:0]);
        2: m_pc = hit ? int'(w[3:0]) : (m_pc + 1) % 16;
        3: begin
          if (m_stk.size() == SD) begin
            m_run = 1'b0; m_err = 1'b1;
          end else begin
            m_stk.push_back((m_pc + 1) % 16);
            m_pc = int'(w[3:0]);
          end
        end
        4: begin
          if (m_stk.size() == 0) begin
            m_run = 1'b0; m_err = 1'b1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
        5: begin m_run = 1'b0; m_done = 1'b1; end
        6: if (hit) m_pc = (m_pc + 1) % 16;
        default: begin m_run = 1'b0; m_err = 1'b1; end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [3:0] e_upc, input logic e_o,
                     input logic e_b, input logic e_d, input logic e_e);
    n_tests++;
    if (upc !== e_upc || out !== e_o || busy !== e_b || done !== e_d || err !== e_e) begin
      n_fail++;
      $display("FAIL %s: got upc=%0d out=%b busy=%b done=%b err=%b, want upc=%0d out=%b busy=%b done=%b err=%b",
               name, upc, out, busy, done, err, e_upc, e_o, e_b, e_d, e_e);
    end
  endtask

  task automatic chk_model(input string name);
    logic mo;
    mo = m_run ? m_mem[m_pc][9] : 1'b0;
    chk(name, 4'(m_pc), mo, m_run, m_done, m_err);
  endtask

  task automatic drive(input logic s, input logic [1:0] c, input logic we,
                       input logic [3:0] a, input logic [IW-1:0] d);
    start = s; cond = c; prog_we = we; prog_addr = a; prog_data = d;
    @(posedge clk);
    m_edge(s, c, we, a, d);
    #1;
  endtask

  task automatic step(input logic s, input logic [1:0] c);
    drive(s, c, 1'b0, 4'd0, 10'd0);
  endtask

  task automatic load(input logic [3:0] a, input logic [IW-1:0] d);
    drive(1'b0, 2'b00, 1'b1, a, d);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cond = 2'b00; prog_we = 1'b0;
    prog_addr = 4'd0; prog_data = 10'd0;
    m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 10'd0;
    #12;
    chk("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // ---- table-driven: sequential step, branch taken/not, start ignored in RUN
    load(4'd0, enc(1'b0, NX, 1'b0, 1'b0, 4'd0));
    load(4'd1, enc(1'b1, BR, 1'b0, 1'b0, 4'd4));
    load(4'd2, enc(1'b1, HL, 1'b0, 1'b0, 4'd0));
    load(4'd4, enc(1'b1, NX, 1'b0, 1'b0, 4'd0));
    load(4'd5, enc(1'b0, HL, 1'b0, 1'b0, 4'd0));
    chk("idle_after_load", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    tbl.push_back('{1'b1, 2'b01, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 2'b01, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b10, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b10, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b10, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0});
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].c);
      chk($sformatf("vec%0d", i), tbl[i].upc, tbl[i].o, tbl[i].b, tbl[i].d, tbl[i].e);
    end

    // ---- WAIT on cond[1]
    load(4'd0, enc(1'b0, NX, 1'b0, 1'b0, 4'd0));
    load(4'd1, enc(1'b0, NX, 1'b0, 1'b0, 4'd0));
    load(4'd2, enc(1'b0, NX, 1'b0, 1'b0, 4'd0));
    load(4'd3, enc(1'b1, WT, 1'b1, 1'b0, 4'd0));
    load(4'd4, enc(1'b0, HL, 1'b0, 1'b0, 4'd0));
    step(1'b1, 2'b00); chk("wait_s0", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00); chk("wait_enter", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00); chk("wait_hold", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 2'b10); chk("wait_release", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("wait_done", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);

    // ---- CALL / RET
    load(4'd2, enc(1'b0, CL, 1'b0, 1'b0, 4'd8));
    load(4'd3, enc(1'b1, HL, 1'b0, 1'b0, 4'd0));
    load(4'd8, enc(1'b1, NX, 1'b0, 1'b0, 4'd0));
    load(4'd9, enc(1'b0, RT, 1'b0, 1'b0, 4'd0));
    step(1'b1, 2'b00);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00); chk("call_at2", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("call_tgt", 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("call_ret", 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("ret_back", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("ret_done", 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);

    // ---- stack overflow on the third nested CALL
    load(4'd0, enc(1'b0, CL, 1'b0, 1'b0, 4'd4));
    load(4'd4, enc(1'b0, CL, 1'b0, 1'b0, 4'd6));
    load(4'd6, enc(1'b1, CL, 1'b0, 1'b0, 4'd8));
    step(1'b1, 2'b00);
    step(1'b0, 2'b00); chk("nest_2", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("nest_3", 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("overflow_err", 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);

    // ---- RET with empty stack, restarted from ERROR
    load(4'd0, enc(1'b0, RT, 1'b0, 1'b0, 4'd0));
    step(1'b1, 2'b00); chk("err_restart", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("underflow_err", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // ---- uPC wrap from 15 to 0
    load(4'd0, enc(1'b0, BR, 1'b0, 1'b0, 4'd15));
    load(4'd15, enc(1'b1, NX, 1'b0, 1'b0, 4'd0));
    load(4'd1, enc(1'b0, HL, 1'b0, 1'b0, 4'd0));
    step(1'b1, 2'b01);
    step(1'b0, 2'b01); chk("wrap_15", 4'd15, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("wrap_0", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("wrap_1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("wrap_done", 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);

    // ---- reserved opcode, then rerun after fixing the word
    load(4'd0, enc(1'b1, RS, 1'b0, 1'b0, 4'd0));
    step(1'b1, 2'b00); chk("rsvd_exec", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("rsvd_err", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    load(4'd0, enc(1'b0, HL, 1'b0, 1'b0, 4'd0));
    step(1'b1, 2'b00); chk("rerun", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b00); chk("rerun_done", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ---- write during RUN ignored, reset mid-RUN
    load(4'd0, enc(1'b0, NX, 1'b0, 1'b0, 4'd0));
    load(4'd1, enc(1'b0, NX, 1'b0, 1'b0, 4'd0));
    load(4'd2, enc(1'b1, WT, 1'b1, 1'b0, 4'd0));
    load(4'd3, enc(1'b0, NX, 1'b0, 1'b0, 4'd0));
    load(4'd4, enc(1'b0, HL, 1'b0, 1'b0, 4'd0));
    step(1'b1, 2'b00);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00); chk("stall", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    load(4'd3, enc(1'b1, HL, 1'b0, 1'b0, 4'd0));
    chk("stall_we", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    chk("reset_midrun", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 2'b10);
    step(1'b0, 2'b10);
    step(1'b0, 2'b10); chk("rr_2", 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b10); chk("we_ignored", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b10); chk("rr_4", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 2'b10); chk("rr_done", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);

    // ---- randomized run against the reference model
    @(negedge clk);
    reset = 1'b1;
    #2;
    m_reset();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) load(4'(i), 10'($urandom));
    chk_model("rand_init");
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) == 0), 2'($urandom), ($urandom_range(0, 7) == 0),
            4'($urandom), 10'($urandom));
      chk_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
